// File: rtl/if_fetch_pkg.sv
// Shared fetch-stage constants and the word-alignment helper.
// Imported by if_fetch and usable by neighbouring pipeline stages.
package if_fetch_pkg;

   localparam int unsigned INST_W       = 32;
   localparam logic [31:0] PC_STEP      = 32'd4;
   localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, pairs each 1-cycle-latency RAM word with its PC,
// absorbs downstream stalls in a one-entry hold buffer and applies execute redirects.
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              jump_en_i,
   input  logic [31:0]       jump_addr_i,
   output logic [31:0]       iram_addr_o,
   input  logic [INST_W-1:0] iram_data_i,
   output logic [INST_W-1:0] inst_o,
   output logic [31:0]       inst_addr_o,
   output logic              inst_valid_o
);

   logic [31:0]       pc_q;
   logic              req_v_q;
   logic [31:0]       rsp_pc_q;
   logic              hold_v_q;
   logic [INST_W-1:0] hold_inst_q;
   logic [31:0]       hold_pc_q;

   // PC and outstanding-request tracking; a stalled issue is simply dropped and re-issued later.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q     <= RESET_PC;
         req_v_q  <= 1'b0;
         rsp_pc_q <= RESET_PC;
      end else if (jump_en_i) begin
         pc_q    <= word_align(jump_addr_i);
         req_v_q <= 1'b0;
      end else if (stall_i) begin
         req_v_q <= 1'b0;
      end else begin
         pc_q     <= pc_q + PC_STEP;
         req_v_q  <= 1'b1;
         rsp_pc_q <= pc_q;
      end
   end

   // Hold buffer captures the live RAM word on the first stalled cycle only.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_v_q    <= 1'b0;
         hold_inst_q <= '0;
         hold_pc_q   <= '0;
      end else if (jump_en_i) begin
         hold_v_q <= 1'b0;
      end else if (stall_i) begin
         if (!hold_v_q && req_v_q) begin
            hold_v_q    <= 1'b1;
            hold_inst_q <= iram_data_i;
            hold_pc_q   <= rsp_pc_q;
         end
      end else begin
         hold_v_q <= 1'b0;
      end
   end

   always_comb begin
      iram_addr_o  = word_align(pc_q);
      inst_valid_o = hold_v_q | req_v_q;
      inst_o       = NOP_INST;
      inst_addr_o  = rsp_pc_q;
      if (hold_v_q) begin
         inst_o      = hold_inst_q;
         inst_addr_o = hold_pc_q;
      end else if (req_v_q) begin
         inst_o      = iram_data_i;
         inst_addr_o = rsp_pc_q;
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios plus a randomized run against
// an in-order delivery model (next expected PC + whether a word is presented).
module tb_if_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        jump_en = 1'b0;
   logic [31:0] jump_addr = '0;
   logic [31:0] iram_addr;
   logic [31:0] iram_data = '0;
   logic [31:0] inst;
   logic [31:0] inst_addr;
   logic        inst_valid;

   logic        rst_w = 1'b1;
   logic [31:0] iram_addr_w;
   logic [31:0] iram_data_w = '0;
   logic [31:0] inst_w;
   logic [31:0] inst_addr_w;
   logic        inst_valid_w;

   int checks = 0;
   int errors = 0;

   // Delivery model: m_valid = a word is presented now; m_pc = address of next word owed.
   logic        m_valid = 1'b0;
   logic [31:0] m_pc = '0;

   localparam logic [31:0] NOP = 32'h0000_0013;

   if_fetch dut (
      .clk          (clk),
      .rst          (rst),
      .stall_i      (stall),
      .jump_en_i    (jump_en),
      .jump_addr_i  (jump_addr),
      .iram_addr_o  (iram_addr),
      .iram_data_i  (iram_data),
      .inst_o       (inst),
      .inst_addr_o  (inst_addr),
      .inst_valid_o (inst_valid)
   );

   if_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
      .clk          (clk),
      .rst          (rst_w),
      .stall_i      (1'b0),
      .jump_en_i    (1'b0),
      .jump_addr_i  (32'h0),
      .iram_addr_o  (iram_addr_w),
      .iram_data_i  (iram_data_w),
      .inst_o       (inst_w),
      .inst_addr_o  (inst_addr_w),
      .inst_valid_o (inst_valid_w)
   );

   always #5 clk = ~clk;

   // RAM with RAM[i] = i, one cycle read latency.
   always @(posedge clk) begin
      iram_data   <= iram_addr >> 2;
      iram_data_w <= iram_addr_w >> 2;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   task automatic drive(input logic r, input logic s, input logic j, input logic [31:0] ja);
      rst       = r;
      stall     = s;
      jump_en   = j;
      jump_addr = ja;
      if (r) begin
         m_valid = 1'b0;
         m_pc    = 32'h0;
      end else if (j) begin
         m_valid = 1'b0;
         m_pc    = {ja[31:2], 2'b00};
      end else if (!s) begin
         if (m_valid) m_pc = m_pc + 32'd4;
         m_valid = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      checks++;
      if (inst_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid: got %0b, required 0", inst_valid);
      end
      checks++;
      if (inst !== NOP) begin
         errors++;
         $display("FAIL reset_inst: got %h, required %h", inst, NOP);
      end
      checks++;
      if (inst_addr !== 32'h0) begin
         errors++;
         $display("FAIL reset_addr: got %h, required 00000000", inst_addr);
      end
   endtask

   task automatic test_stream();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 1'b0, 32'h0);
         checks++;
         if (inst_valid !== 1'b1 || inst_addr !== 32'(4 * i) || inst !== 32'(i)) begin
            errors++;
            $display("FAIL stream[%0d]: got v=%0b a=%h d=%h, required v=1 a=%h d=%h",
                     i, inst_valid, inst_addr, inst, 32'(4 * i), 32'(i));
         end
      end
   endtask

   task automatic test_stall();
      logic [31:0] exp_a [3];
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 32'h0);
      // Output now shows 0x8; hold it for three stalled cycles.
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 1'b0, 32'h0);
         checks++;
         if (inst_valid !== 1'b1 || inst_addr !== 32'h8 || inst !== 32'h2) begin
            errors++;
            $display("FAIL stall_hold[%0d]: got v=%0b a=%h d=%h, required v=1 a=8 d=2",
                     i, inst_valid, inst_addr, inst);
         end
      end
      exp_a[0] = 32'hC;
      exp_a[1] = 32'h10;
      exp_a[2] = 32'h14;
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b0, 32'h0);
         checks++;
         if (inst_valid !== 1'b1 || inst_addr !== exp_a[i] || inst !== (exp_a[i] >> 2)) begin
            errors++;
            $display("FAIL stall_release[%0d]: got v=%0b a=%h d=%h, required v=1 a=%h d=%h",
                     i, inst_valid, inst_addr, inst, exp_a[i], exp_a[i] >> 2);
         end
      end
   endtask

   task automatic test_jump();
      drive(1'b0, 1'b0, 1'b1, 32'h40);
      checks++;
      if (inst_valid !== 1'b0 || inst !== NOP) begin
         errors++;
         $display("FAIL jump_bubble: got v=%0b d=%h, required v=0 d=%h", inst_valid, inst, NOP);
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      checks++;
      if (inst_valid !== 1'b1 || inst_addr !== 32'h40 || inst !== 32'h10) begin
         errors++;
         $display("FAIL jump_target: got v=%0b a=%h d=%h, required v=1 a=40 d=10",
                  inst_valid, inst_addr, inst);
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      checks++;
      if (inst_valid !== 1'b1 || inst_addr !== 32'h44 || inst !== 32'h11) begin
         errors++;
         $display("FAIL jump_next: got v=%0b a=%h d=%h, required v=1 a=44 d=11",
                  inst_valid, inst_addr, inst);
      end
   endtask

   task automatic test_jump_during_stall();
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      drive(1'b0, 1'b1, 1'b1, 32'h40);
      checks++;
      if (inst_valid !== 1'b0) begin
         errors++;
         $display("FAIL jump_stall_bubble: got v=%0b, required 0", inst_valid);
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      checks++;
      if (inst_valid !== 1'b1 || inst_addr !== 32'h40 || inst !== 32'h10) begin
         errors++;
         $display("FAIL jump_stall_target: got v=%0b a=%h d=%h, required v=1 a=40 d=10",
                  inst_valid, inst_addr, inst);
      end
   endtask

   task automatic test_misaligned_jump();
      drive(1'b0, 1'b0, 1'b1, 32'h43);
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      checks++;
      if (inst_valid !== 1'b1 || inst_addr !== 32'h40 || inst !== 32'h10) begin
         errors++;
         $display("FAIL misaligned_jump: got v=%0b a=%h d=%h, required v=1 a=40 d=10",
                  inst_valid, inst_addr, inst);
      end
   endtask

   task automatic test_wrap();
      rst_w = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (inst_valid_w !== 1'b1 || inst_addr_w !== 32'hFFFF_FFFC || inst_w !== 32'h3FFF_FFFF) begin
         errors++;
         $display("FAIL wrap_first: got v=%0b a=%h d=%h, required v=1 a=fffffffc d=3fffffff",
                  inst_valid_w, inst_addr_w, inst_w);
      end
      @(posedge clk);
      #1;
      checks++;
      if (inst_valid_w !== 1'b1 || inst_addr_w !== 32'h0 || inst_w !== 32'h0) begin
         errors++;
         $display("FAIL wrap_next: got v=%0b a=%h d=%h, required v=1 a=00000000 d=0",
                  inst_valid_w, inst_addr_w, inst_w);
      end
   endtask

   task automatic test_reset_mid_stall();
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      checks++;
      if (inst_valid !== 1'b0 || inst !== NOP || inst_addr !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid_stall: got v=%0b a=%h d=%h, required v=0 a=00000000 d=%h",
                  inst_valid, inst_addr, inst, NOP);
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      checks++;
      if (inst_valid !== 1'b1 || inst_addr !== 32'h0 || inst !== 32'h0) begin
         errors++;
         $display("FAIL reset_restart: got v=%0b a=%h d=%h, required v=1 a=00000000 d=0",
                  inst_valid, inst_addr, inst);
      end
   endtask

   task automatic test_random();
      logic        r, s, j;
      logic [31:0] ja;
      for (int c = 0; c < 3000; c++) begin
         checks++;
         if (inst_valid !== m_valid) begin
            errors++;
            $display("FAIL random_valid[%0d]: got %0b, required %0b", c, inst_valid, m_valid);
         end else if (m_valid && (inst_addr !== m_pc || inst !== (m_pc >> 2))) begin
            errors++;
            $display("FAIL random_word[%0d]: got a=%h d=%h, required a=%h d=%h",
                     c, inst_addr, inst, m_pc, m_pc >> 2);
         end else if (!m_valid && inst !== NOP) begin
            errors++;
            $display("FAIL random_nop[%0d]: got %h, required %h", c, inst, NOP);
         end
         r  = ($urandom_range(0, 199) == 0);
         j  = ($urandom_range(0, 9) == 0);
         s  = ($urandom_range(0, 9) < 3);
         ja = $urandom;
         drive(r, s, j, ja);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_jump();
      test_jump_during_stall();
      test_misaligned_jump();
      test_wrap();
      test_reset_mid_stall();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
